// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte streams,
// locking the transmitter to one requester until the last byte of its packet.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int IDX_W         = 2,
    parameter int START_TIMEOUT = 16,
    parameter int LOCK_TIMEOUT  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    // Requester i offers a byte with req_valid[i] and must hold req_byte/req_last
    // until the single-cycle req_ack[i]; the next byte may appear the cycle after.
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 uart_tx_start,
    output logic [7:0]           uart_tx_byte,
    input  logic                 uart_tx_ready,
    input  logic                 uart_tx_sending,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [15:0]          bytes_sent,
    output logic [1:0]           dbg_state
);

    localparam int ST_W = $clog2(START_TIMEOUT + 1);
    localparam int LT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned N_U = NUM_REQ;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAPTURE   = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] sel_idx;
    logic             found;
    logic             lock;
    logic [ST_W-1:0]  start_timer;
    logic [LT_W-1:0]  idle_timer;

    logic take_arb;
    logic lock_expire;
    logic idle_tick;
    logic start_tick;
    logic start_fail;
    logic frame_done;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned       off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N_U) sum = sum - N_U;
        return sum[IDX_W-1:0];
    endfunction

    // First valid requester scanning from rr_ptr upward, wrapping.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < N_U; i++) begin
            if (!found && req_valid[wrap_add(rr_ptr, i)]) begin
                found   = 1'b1;
                sel_idx = wrap_add(rr_ptr, i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state    = state;
        take_arb      = 1'b0;
        lock_expire   = 1'b0;
        idle_tick     = 1'b0;
        start_tick    = 1'b0;
        start_fail    = 1'b0;
        frame_done    = 1'b0;
        uart_tx_start = 1'b0;
        req_ack       = '0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (lock) begin
                    if (req_valid[owner] && uart_tx_ready) next_state = CAPTURE;
                    else if (idle_timer == LT_W'(LOCK_TIMEOUT - 1)) lock_expire = 1'b1;
                    else idle_tick = 1'b1;
                end else if (found && uart_tx_ready) begin
                    take_arb   = 1'b1;
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                req_ack    = grant;
                next_state = START;
            end
            START: begin
                uart_tx_start = 1'b1;
                if (uart_tx_sending) begin
                    next_state = WAIT_DONE;
                end else if (start_timer == ST_W'(START_TIMEOUT - 1)) begin
                    start_fail = 1'b1;
                    next_state = IDLE;
                end else begin
                    start_tick = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_sending && uart_tx_ready) begin
                    frame_done = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            owner        <= '0;
            grant        <= '0;
            lock         <= 1'b0;
            start_timer  <= '0;
            idle_timer   <= '0;
            uart_tx_byte <= 8'h00;
            err_timeout  <= 1'b0;
            bytes_sent   <= 16'h0000;
        end else begin
            if (take_arb) begin
                owner <= sel_idx;
                grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
            end
            if (state == CAPTURE) begin
                uart_tx_byte <= req_byte[{owner, 3'b000} +: 8];
                lock         <= ~req_last[owner];
                start_timer  <= '0;
                idle_timer   <= '0;
            end
            if (idle_tick)  idle_timer  <= idle_timer + LT_W'(1);
            if (start_tick) start_timer <= start_timer + ST_W'(1);
            // A stalled owner or an unanswered start both give up the transmitter;
            // the failed byte was already acked and is not retried.
            if (lock_expire || start_fail) begin
                lock       <= 1'b0;
                grant      <= '0;
                rr_ptr     <= wrap_add(owner, 1);
                idle_timer <= '0;
            end
            if (start_fail) err_timeout <= 1'b1;
            if (frame_done) begin
                bytes_sent <= bytes_sent + 16'd1;
                if (!lock) begin
                    grant  <= '0;
                    rr_ptr <= wrap_add(owner, 1);
                end
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requesters, a small UART transmitter
// model and per-scenario tasks with hand-computed expectations.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int START_TIMEOUT = 16;
    localparam int LOCK_TIMEOUT  = 1024;
    localparam int ACK_DELAY     = 2;
    localparam int FRAME_LEN     = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_byte;
    logic [3:0]  req_last;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic        uart_tx_start;
    logic [7:0]  uart_tx_byte;
    logic        uart_tx_ready;
    logic        uart_tx_sending;
    logic        busy;
    logic        err_timeout;
    logic [15:0] bytes_sent;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [8:0] src_mem [4][32];
    int         src_rd  [4];
    int         src_wr  [4];
    bit         pend    [4];

    logic [7:0] exp_q[$];
    logic [7:0] seen_q[$];
    int         svc_q[$];
    int         ack_cnt [4];
    int         byte_err;
    bit         uart_dead;
    bit         m_busy;
    bit         m_nochk;
    int         m_cnt;
    logic [7:0] m_byte;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IDX_W(2),
        .START_TIMEOUT(START_TIMEOUT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_byte(req_byte),
        .req_last(req_last),
        .req_ack(req_ack),
        .grant(grant),
        .uart_tx_start(uart_tx_start),
        .uart_tx_byte(uart_tx_byte),
        .uart_tx_ready(uart_tx_ready),
        .uart_tx_sending(uart_tx_sending),
        .busy(busy),
        .err_timeout(err_timeout),
        .bytes_sent(bytes_sent),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want completion within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- requester driver ----------------
    // Next byte is presented one cycle after the ack, as the requester contract allows.
    initial begin
        req_valid = '0;
        req_byte  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) begin
                    src_rd[i]++;
                    pend[i] = 1'b0;
                end
                if (src_rd[i] < src_wr[i]) begin
                    req_valid[i]       = 1'b1;
                    req_byte[8*i +: 8] = src_mem[i][src_rd[i]][7:0];
                    req_last[i]        = src_mem[i][src_rd[i]][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
                if (req_ack[i]) pend[i] = 1'b1;
            end
        end
    end

    task automatic push(input int idx, input logic [7:0] b, input logic last);
        src_mem[idx][src_wr[idx]] = {last, b};
        src_wr[idx]++;
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < 4; i++)
            if (src_rd[i] != src_wr[i] || pend[i]) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (req_ack[i]) ack_cnt[i]++;
            if (dbg_state == 2'd1)
                for (int i = 0; i < 4; i++) if (grant[i]) svc_q.push_back(i);
        end
    end

    // ---------------- UART transmitter model ----------------
    initial begin
        uart_tx_ready   = 1'b1;
        uart_tx_sending = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) m_nochk = 1'b1;
            if (!m_busy) begin
                if (uart_tx_start && !uart_dead) begin
                    m_cnt++;
                    if (m_cnt >= ACK_DELAY) begin
                        m_busy          = 1'b1;
                        m_nochk         = 1'b0;
                        m_cnt           = 0;
                        m_byte          = uart_tx_byte;
                        uart_tx_sending = 1'b1;
                        uart_tx_ready   = 1'b0;
                        seen_q.push_back(uart_tx_byte);
                    end
                end else begin
                    m_cnt = 0;
                end
            end else begin
                if (!m_nochk && uart_tx_byte !== m_byte) byte_err++;
                m_cnt++;
                if (m_cnt >= FRAME_LEN) begin
                    m_busy          = 1'b0;
                    m_cnt           = 0;
                    uart_tx_sending = 1'b0;
                    uart_tx_ready   = 1'b1;
                end
            end
        end
    end

    task automatic wait_quiet(input int budget, output bit ok);
        int calm = 0;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (src_empty() && !busy && !m_busy) calm++;
            else calm = 0;
            if (calm >= 2) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (uart_tx_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", uart_tx_start); end
        total++; if (bytes_sent !== 16'd0) begin bad++; $display("FAIL reset_bytes_sent: got %0d want 0", bytes_sent); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        total++; if (uart_tx_byte !== 8'h00) begin bad++; $display("FAIL reset_byte: got %h want 00", uart_tx_byte); end
        total++; if (req_ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b want 0000", req_ack); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int s0 = svc_q.size();
        int b0 = seen_q.size();
        int want_svc [5] = '{0, 1, 2, 3, 0};
        bit ok;
        push(0, 8'hA0, 1'b1);
        push(1, 8'hA1, 1'b1);
        push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1);
        push(0, 8'hA4, 1'b1);
        exp_q.delete();
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3); exp_q.push_back(8'hA4);
        wait_quiet(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_done: got busy want idle within 300 cycles"); end
        total++; if (svc_q.size() - s0 != 5) begin bad++; $display("FAIL rr_count: got %0d want 5", svc_q.size() - s0); end
        for (int k = 0; k < 5; k++) begin
            int got_i;
            logic [7:0] got_b;
            got_i = (s0 + k < svc_q.size()) ? svc_q[s0 + k] : -1;
            got_b = (b0 + k < seen_q.size()) ? seen_q[b0 + k] : 8'hxx;
            total++; if (got_i != want_svc[k]) begin bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, got_i, want_svc[k]); end
            total++; if (got_b !== exp_q[k]) begin bad++; $display("FAIL rr_byte[%0d]: got %h want %h", k, got_b, exp_q[k]); end
        end
        total++; if (bytes_sent !== 16'd5) begin bad++; $display("FAIL rr_bytes_sent: got %0d want 5", bytes_sent); end
    endtask

    task automatic test_packet_lock();
        int s0 = svc_q.size();
        int b0 = seen_q.size();
        int want_svc [4] = '{0, 0, 0, 2};
        bit ok = 1'b0;
        push(0, 8'h10, 1'b0);
        push(0, 8'h11, 1'b0);
        push(0, 8'h12, 1'b1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (grant === 4'b0001) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL lock_first_grant: got %b want 0001", grant); end
        push(2, 8'h22, 1'b1);
        exp_q.delete();
        exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h22);
        wait_quiet(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL lock_done: got busy want idle within 300 cycles"); end
        for (int k = 0; k < 4; k++) begin
            int got_i;
            logic [7:0] got_b;
            got_i = (s0 + k < svc_q.size()) ? svc_q[s0 + k] : -1;
            got_b = (b0 + k < seen_q.size()) ? seen_q[b0 + k] : 8'hxx;
            total++; if (got_i != want_svc[k]) begin bad++; $display("FAIL lock_owner[%0d]: got %0d want %0d", k, got_i, want_svc[k]); end
            total++; if (got_b !== exp_q[k]) begin bad++; $display("FAIL lock_byte[%0d]: got %h want %h", k, got_b, exp_q[k]); end
        end
        total++; if (bytes_sent !== 16'd9) begin bad++; $display("FAIL lock_bytes_sent: got %0d want 9", bytes_sent); end
    endtask

    task automatic test_single_byte();
        int b0 = seen_q.size();
        int a0 = ack_cnt[0], a1 = ack_cnt[1], a2 = ack_cnt[2], a3 = ack_cnt[3];
        int e0 = byte_err;
        logic [3:0] g_or = 4'b0000;
        push(1, 8'h41, 1'b1);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy) g_or = g_or | grant;
        end
        total++; if (ack_cnt[1] - a1 != 1) begin bad++; $display("FAIL single_ack1: got %0d want 1", ack_cnt[1] - a1); end
        total++; if (ack_cnt[0] - a0 + ack_cnt[2] - a2 + ack_cnt[3] - a3 != 0) begin
            bad++; $display("FAIL single_other_acks: got %0d want 0", ack_cnt[0] - a0 + ack_cnt[2] - a2 + ack_cnt[3] - a3);
        end
        total++; if (seen_q.size() - b0 != 1 || seen_q[seen_q.size() - 1] !== 8'h41) begin
            bad++; $display("FAIL single_byte: got %0d frames last %h want 1 frame 41", seen_q.size() - b0, seen_q[seen_q.size() - 1]);
        end
        total++; if (byte_err != e0) begin bad++; $display("FAIL single_byte_stable: got %0d changes want 0", byte_err - e0); end
        total++; if (g_or !== 4'b0010) begin bad++; $display("FAIL single_grant_busy: got %b want 0010", g_or); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_grant_after: got %b want 0000", grant); end
        total++; if (bytes_sent !== 16'd10) begin bad++; $display("FAIL single_bytes_sent: got %0d want 10", bytes_sent); end
    endtask

    task automatic test_start_timeout();
        int b0 = seen_q.size();
        int n = 0;
        bit ok = 1'b0;
        uart_dead = 1'b1;
        push(3, 8'h33, 1'b1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (uart_tx_start === 1'b1) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL to_start_seen: got 0 want 1 within 30 cycles"); end
        while (uart_tx_start === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        total++; if (n != START_TIMEOUT) begin bad++; $display("FAIL to_start_len: got %0d want %0d", n, START_TIMEOUT); end
        repeat (3) @(negedge clk);
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err_timeout); end
        total++; if (bytes_sent !== 16'd10) begin bad++; $display("FAIL to_bytes_sent: got %0d want 10", bytes_sent); end
        uart_dead = 1'b0;
        push(1, 8'h51, 1'b1);
        wait_quiet(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_recover_done: got busy want idle within 200 cycles"); end
        total++; if (seen_q.size() - b0 != 1 || seen_q[seen_q.size() - 1] !== 8'h51) begin
            bad++; $display("FAIL to_recover_byte: got %0d frames last %h want 1 frame 51", seen_q.size() - b0, seen_q[seen_q.size() - 1]);
        end
        total++; if (bytes_sent !== 16'd11) begin bad++; $display("FAIL to_recover_count: got %0d want 11", bytes_sent); end
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got %b want 1", err_timeout); end
    endtask

    task automatic test_lock_timeout();
        int b0 = seen_q.size();
        int n = 0;
        bit ok = 1'b0;
        push(0, 8'h60, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (grant === 4'b0001) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL lt_grant0: got %b want 0001", grant); end
        push(3, 8'h63, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bytes_sent === 16'd12) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL lt_first_frame: got %0d want 12", bytes_sent); end
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL lt_lock_held: got %b want 0001", grant); end
        while (grant !== 4'b1000 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        total++; if (n != LOCK_TIMEOUT + 1) begin bad++; $display("FAIL lt_release_cycles: got %0d want %0d", n, LOCK_TIMEOUT + 1); end
        wait_quiet(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL lt_done: got busy want idle within 200 cycles"); end
        exp_q.delete();
        exp_q.push_back(8'h60); exp_q.push_back(8'h63);
        for (int k = 0; k < 2; k++) begin
            logic [7:0] got_b;
            got_b = (b0 + k < seen_q.size()) ? seen_q[b0 + k] : 8'hxx;
            total++; if (got_b !== exp_q[k]) begin bad++; $display("FAIL lt_byte[%0d]: got %h want %h", k, got_b, exp_q[k]); end
        end
        total++; if (bytes_sent !== 16'd13) begin bad++; $display("FAIL lt_bytes_sent: got %0d want 13", bytes_sent); end
    endtask

    task automatic test_reset_mid_frame();
        int s0;
        int want_svc [2] = '{0, 3};
        bit ok = 1'b0;
        push(1, 8'h71, 1'b1);
        wait_quiet(200, ok);
        total++; if (bytes_sent !== 16'd14) begin bad++; $display("FAIL rm_pre_count: got %0d want 14", bytes_sent); end
        push(2, 8'h72, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (dbg_state === 2'd3) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL rm_wait_done_seen: got state %0d want 3", dbg_state); end
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rm_grant: got %b want 0000", grant); end
        total++; if (uart_tx_start !== 1'b0) begin bad++; $display("FAIL rm_start: got %b want 0", uart_tx_start); end
        total++; if (bytes_sent !== 16'd0) begin bad++; $display("FAIL rm_bytes_sent: got %0d want 0", bytes_sent); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rm_err: got %b want 0", err_timeout); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s0 = svc_q.size();
        push(3, 8'h73, 1'b1);
        push(0, 8'h70, 1'b1);
        wait_quiet(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_done: got busy want idle within 300 cycles"); end
        for (int k = 0; k < 2; k++) begin
            int got_i;
            got_i = (s0 + k < svc_q.size()) ? svc_q[s0 + k] : -1;
            total++; if (got_i != want_svc[k]) begin bad++; $display("FAIL rm_order[%0d]: got %0d want %0d", k, got_i, want_svc[k]); end
        end
        total++; if (bytes_sent !== 16'd2) begin bad++; $display("FAIL rm_post_count: got %0d want 2", bytes_sent); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_single_byte();
        test_start_timeout();
        test_lock_timeout();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters.
- Round-robin arbitration, with packet locking so a multi-byte message is never interleaved with another requester's bytes.
- Sequences the transmitter's start/ready/sending handshake and holds the byte stable for the whole frame.
- Sits between message producers (status reporters, debug dumpers) and the single UART TX pin driver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of requester index; must equal ceil(log2(NUM_REQ)).
- START_TIMEOUT, 16, cycles to wait for uart_tx_sending after asserting uart_tx_start.
- LOCK_TIMEOUT, 1024, idle cycles a locked owner may stall before the lock is forcibly released.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_byte  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of the requester's packet.
- req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i consumed.
- grant  out  NUM_REQ  one-hot current owner; all zero when no owner.
- uart_tx_start  out  1  start request to the transmitter.
- uart_tx_byte  out  8  byte to transmit, stable from capture until frame done.
- uart_tx_ready  in  1  transmitter idle.
- uart_tx_sending  in  1  transmitter busy with a frame.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky: a start was not acknowledged within START_TIMEOUT.
- bytes_sent  out  16  count of frames completed; wraps at 65535 -> 0.

Behaviour:
- Reset (async): state IDLE; outputs zero (req_ack, grant, uart_tx_start, uart_tx_byte, busy, err_timeout, bytes_sent); rr_ptr=0; lock=0; timers=0.
- States: IDLE, CAPTURE, START, WAIT_DONE.
- IDLE, lock=1:
  - If owner req_valid=1 and uart_tx_ready=1 -> CAPTURE.
  - Otherwise the idle timer increments.
  - When the idle timer reaches LOCK_TIMEOUT: clear lock and grant, set rr_ptr=owner+1 mod NUM_REQ.
- IDLE, lock=0:
  - If any req_valid=1 and uart_tx_ready=1: select the first valid index scanning rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
  - Set grant one-hot for the selected index -> CAPTURE.
- CAPTURE (1 cycle):
  - uart_tx_byte <= owner byte; req_ack[owner] pulses this cycle.
  - lock <= ~req_last[owner]; start timer=0 -> START.
- START:
  - uart_tx_start=1.
  - When uart_tx_sending=1: drop uart_tx_start -> WAIT_DONE.
  - If the timer reaches START_TIMEOUT first: set err_timeout, drop uart_tx_start, byte is discarded (not re-queued), packet lock is cleared -> IDLE.
- WAIT_DONE:
  - When uart_tx_sending=0 and uart_tx_ready=1: bytes_sent++.
  - If lock=0: grant cleared, rr_ptr=owner+1 mod NUM_REQ.
  - -> IDLE.
- Throughput: minimum 1 idle cycle between frames (IDLE -> CAPTURE -> START). Back-to-back bytes of a locked packet must not be interrupted by other requesters.
- Requester contract: hold req_byte and req_last stable while req_valid=1 until req_ack; next byte may be presented the cycle after req_ack.
- Simultaneous requests: exactly one grant; ties resolved purely by rr_ptr order.
- req_valid dropped by a non-owner mid-arbitration: ignored, no ack issued.
- uart_tx_sending already high in IDLE (foreign use): arbiter does not leave IDLE until uart_tx_ready=1.
- Reset mid-frame: everything returns to reset values immediately; no req_ack is issued for the in-flight byte. The transmitter finishes its frame independently.

Test Plan:
- Single byte: req_valid=0010, req_byte[15:8]=0x41, req_last[1]=1, UART model acks after 2 cycles. Required: req_ack[1] one pulse; uart_tx_byte=0x41 held through frame; grant=0010 then 0000; bytes_sent=1.
- Round robin: req_valid=1111 continuously, all single-byte packets. Required: service order 0,1,2,3,0; no index serviced twice before all others.
- Packet lock: req0 sends 3 bytes (0x10, 0x11, 0x12 with last on 0x12) while req2 is valid. Required: uart sees 0x10, 0x11, 0x12 then req2's byte; grant stays 0001 for all three frames.
- Start timeout: UART model never raises uart_tx_sending. Required: uart_tx_start high for exactly START_TIMEOUT cycles; err_timeout=1 sticky; bytes_sent unchanged; next requester served when the model recovers.
- Lock timeout: req0 sends a byte with req_last=0, then drops req_valid; req3 is waiting. Required: after LOCK_TIMEOUT idle cycles, grant moves to 1000.
- Reset mid-frame: assert rst during WAIT_DONE. Required: busy, grant, uart_tx_start and bytes_sent all 0 in the same cycle; after release, req0 has first priority.
